// File: rtl/mem_req_arbiter.sv
// Four-client round-robin arbiter onto a two-port memory, with same-address
// hazard blocking, read-response routing and a saturating hazard counter.

module mem_rsp_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [1:0]            lane_id,
  input  logic                  p0_vld,
  input  logic [1:0]            p0_id,
  input  logic                  p1_vld,
  input  logic [1:0]            p1_id,
  input  logic [DATA_WIDTH-1:0] rdata0,
  input  logic [DATA_WIDTH-1:0] rdata1,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic hit0, hit1;
  assign hit0  = p0_vld && (p0_id == lane_id);
  assign hit1  = p1_vld && (p1_id == lane_id);
  assign vld   = hit0 | hit1;
  assign rdata = hit0 ? rdata0 : (hit1 ? rdata1 : '0);
endmodule

module mem_req_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req_valid,
  output logic [3:0]              req_ready,
  input  logic [3:0]              req_we,
  input  logic [4*DATA_DEPTH-1:0] req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_wdata,
  output logic [3:0]              rsp_valid,
  output logic [4*DATA_WIDTH-1:0] rsp_rdata,
  output logic                    mem_we0,
  output logic [DATA_DEPTH-1:0]   mem_addr0,
  output logic [DATA_WIDTH-1:0]   mem_wdata0,
  input  logic [DATA_WIDTH-1:0]   mem_rdata0,
  output logic                    mem_we1,
  output logic [DATA_DEPTH-1:0]   mem_addr1,
  output logic [DATA_WIDTH-1:0]   mem_wdata1,
  input  logic [DATA_WIDTH-1:0]   mem_rdata1,
  output logic [15:0]             conflict_cnt
);
  localparam int NC = 4;

  logic [NC-1:0][DATA_DEPTH-1:0] addr_v;
  logic [NC-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NC-1:0][DATA_WIDTH-1:0] rdata_v;
  assign addr_v    = req_addr;
  assign wdata_v   = req_wdata;
  assign rsp_rdata = rdata_v;

  logic [1:0] rr_ptr;
  logic       gnt_a_vld, gnt_b_vld, hazard;
  logic [1:0] gnt_a, gnt_b, c;

  // Grants are suppressed while reset is held so the ports go idle at once.
  always_comb begin
    gnt_a_vld = 1'b0;
    gnt_a     = 2'd0;
    gnt_b_vld = 1'b0;
    gnt_b     = 2'd0;
    hazard    = 1'b0;
    c         = 2'd0;
    for (int k = 0; k < NC; k++) begin
      c = rr_ptr + 2'(k);
      if (rst_n && req_valid[c]) begin
        if (!gnt_a_vld) begin
          gnt_a_vld = 1'b1;
          gnt_a     = c;
        end else if (!gnt_b_vld) begin
          if ((addr_v[c] == addr_v[gnt_a]) && (req_we[c] || req_we[gnt_a]))
            hazard = 1'b1;
          else begin
            gnt_b_vld = 1'b1;
            gnt_b     = c;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_a_vld) req_ready[gnt_a] = 1'b1;
    if (gnt_b_vld) req_ready[gnt_b] = 1'b1;
  end

  assign mem_we0    = gnt_a_vld && req_we[gnt_a];
  assign mem_addr0  = gnt_a_vld ? addr_v[gnt_a]  : '0;
  assign mem_wdata0 = gnt_a_vld ? wdata_v[gnt_a] : '0;
  assign mem_we1    = gnt_b_vld && req_we[gnt_b];
  assign mem_addr1  = gnt_b_vld ? addr_v[gnt_b]  : '0;
  assign mem_wdata1 = gnt_b_vld ? wdata_v[gnt_b] : '0;

  // One {valid, client} tag per port; memory returns data the next cycle.
  logic       p0_vld, p1_vld;
  logic [1:0] p0_id, p1_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= 2'd0;
      p0_vld       <= 1'b0;
      p0_id        <= 2'd0;
      p1_vld       <= 1'b0;
      p1_id        <= 2'd0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_b_vld)      rr_ptr <= gnt_b + 2'd1;
      else if (gnt_a_vld) rr_ptr <= gnt_a + 2'd1;
      p0_vld <= gnt_a_vld && !req_we[gnt_a];
      p0_id  <= gnt_a;
      p1_vld <= gnt_b_vld && !req_we[gnt_b];
      p1_id  <= gnt_b;
      if (hazard && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_lane
    mem_rsp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .lane_id (2'(i)),
      .p0_vld  (p0_vld),
      .p0_id   (p0_id),
      .p1_vld  (p1_vld),
      .p1_id   (p1_id),
      .rdata0  (mem_rdata0),
      .rdata1  (mem_rdata1),
      .vld     (rsp_valid[i]),
      .rdata   (rdata_v[i])
    );
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized + directed bench for mem_req_arbiter: reference model predicts
// grants/ports, a scoreboard queue per client checks read responses.

module tb_mem_req_arbiter;
  localparam int W = 16;
  localparam int D = 4;

  logic           clk, rst_n;
  logic [3:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [4*D-1:0] req_addr;
  logic [4*W-1:0] req_wdata, rsp_rdata;
  logic           mem_we0, mem_we1;
  logic [D-1:0]   mem_addr0, mem_addr1;
  logic [W-1:0]   mem_wdata0, mem_wdata1, mem_rdata0, mem_rdata1;
  logic [15:0]    conflict_cnt;

  mem_req_arbiter #(.DATA_WIDTH(W), .DATA_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_we0(mem_we0), .mem_addr0(mem_addr0), .mem_wdata0(mem_wdata0), .mem_rdata0(mem_rdata0),
    .mem_we1(mem_we1), .mem_addr1(mem_addr1), .mem_wdata1(mem_wdata1), .mem_rdata1(mem_rdata1),
    .conflict_cnt(conflict_cnt)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  // Memory stub: registered read, writes land at the edge.
  logic [W-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we0) mem[mem_addr0] <= mem_wdata0;
    if (mem_we1) mem[mem_addr1] <= mem_wdata1;
    mem_rdata0 <= mem[mem_addr0];
    mem_rdata1 <= mem[mem_addr1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic [W-1:0] d; } exp_t;
  exp_t       exp_q[4][$];
  logic [W-1:0] m_mem [16];
  int         m_rr, m_cnt;
  initial for (int i = 0; i < 16; i++) m_mem[i] = '0;

  // Monitor: pops the client's expected response whenever rsp_valid shows up.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (rsp_valid[i]) begin
          if (exp_q[i].size() == 0) check("rsp_spurious", 32'(i), 32'hFF);
          else begin
            mon_e = exp_q[i].pop_front();
            check("rsp_cycle", cyc, mon_e.cyc);
            check("rsp_data", 32'(rsp_rdata[i*W +: W]), 32'(mon_e.d));
          end
        end else begin
          if (rsp_rdata[i*W +: W] !== '0) check("rsp_idle_zero", 32'(rsp_rdata[i*W +: W]), 0);
          if (exp_q[i].size() > 0 && exp_q[i][0].cyc <= cyc) begin
            mon_e = exp_q[i].pop_front();
            check("rsp_missing", 32'(i), 32'hFF);
          end
        end
      end
    end
  end

  // Drives one cycle of requests, checks combinational outputs against the
  // model, then advances the model as the clock edge will.
  task automatic drive(input logic [3:0] v, input logic [3:0] w,
                       input logic [3:0][D-1:0] a, input logic [3:0][W-1:0] d,
                       input bit chk, output logic [3:0] gr);
    int ga, gb, cl;
    bit hz;
    logic [3:0] er;
    @(negedge clk);
    req_valid = v; req_we = w; req_addr = a; req_wdata = d;
    #1;
    ga = -1; gb = -1; hz = 0;
    for (int k = 0; k < 4; k++) begin
      cl = (m_rr + k) % 4;
      if (v[cl]) begin
        if (ga < 0) ga = cl;
        else if (gb < 0) begin
          if (a[cl] == a[ga] && (w[cl] || w[ga])) hz = 1;
          else gb = cl;
        end
      end
    end
    er = '0;
    if (ga >= 0) er[ga] = 1'b1;
    if (gb >= 0) er[gb] = 1'b1;
    if (chk) begin
      check("req_ready", 32'(req_ready), 32'(er));
      check("conflict_cnt", 32'(conflict_cnt), m_cnt);
      if (ga < 0) begin
        check("port0_idle", {mem_we0, 3'd0, mem_addr0, mem_wdata0}, 0);
      end else begin
        check("we0", 32'(mem_we0), 32'(w[ga]));
        check("addr0", 32'(mem_addr0), 32'(a[ga]));
        if (w[ga]) check("wdata0", 32'(mem_wdata0), 32'(d[ga]));
      end
      if (gb < 0) begin
        check("port1_idle", {mem_we1, 3'd0, mem_addr1, mem_wdata1}, 0);
      end else begin
        check("we1", 32'(mem_we1), 32'(w[gb]));
        check("addr1", 32'(mem_addr1), 32'(a[gb]));
        if (w[gb]) check("wdata1", 32'(mem_wdata1), 32'(d[gb]));
      end
    end
    if (ga >= 0 && !w[ga]) exp_q[ga].push_back('{cyc + 1, m_mem[a[ga]]});
    if (gb >= 0 && !w[gb]) exp_q[gb].push_back('{cyc + 1, m_mem[a[gb]]});
    if (ga >= 0 && w[ga]) m_mem[a[ga]] = d[ga];
    if (gb >= 0 && w[gb]) m_mem[a[gb]] = d[gb];
    if (gb >= 0) m_rr = (gb + 1) % 4;
    else if (ga >= 0) m_rr = (ga + 1) % 4;
    if (hz && m_cnt < 65535) m_cnt++;
    gr = er;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    req_valid = 4'b1111; req_we = 4'b1111; req_addr = '0; req_wdata = '1;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_conflict_cnt", 32'(conflict_cnt), 0);
    check("rst_mem_we", {mem_we1, mem_we0}, 0);
    check("rst_req_ready", 32'(req_ready), 0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    m_rr = 0; m_cnt = 0;
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  logic [3:0]        gr, pv, pw;
  logic [3:0][D-1:0] pa;
  logic [3:0][W-1:0] pd;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    m_rr = 0; m_cnt = 0;
    #3;
    check("init_rsp_valid", 32'(rsp_valid), 0);
    check("init_conflict_cnt", 32'(conflict_cnt), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Client 2 writes then reads back addr 5.
    pa = '0; pd = '0; pa[2] = 4'd5; pd[2] = 16'hBEEF;
    drive(4'b0100, 4'b0100, pa, pd, 1, gr);
    check("single_wr_gnt", 32'(gr), 32'b0100);
    drive(4'b0100, 4'b0000, pa, pd, 1, gr);
    check("single_rd_gnt", 32'(gr), 32'b0100);
    drive(4'b0000, 4'b0000, pa, pd, 1, gr);

    // Random phase: clients hold a request until granted.
    pv = '0; pw = '0; pa = '0; pd = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i] = 1'b1;
          pw[i] = $urandom_range(0, 2) == 0;
          pa[i] = $urandom_range(0, 1) ? D'($urandom_range(0, 3)) : D'($urandom_range(0, 15));
          pd[i] = W'($urandom);
        end
      end
      drive(pv, pw, pa, pd, 1, gr);
      pv = pv & ~gr;
    end

    do_reset();

    // After release: four distinct reads, rr starts at client 0.
    pa = '0; pd = '0;
    for (int i = 0; i < 4; i++) pa[i] = D'(i + 1);
    drive(4'b1111, 4'b0000, pa, pd, 1, gr);
    check("all4_first", 32'(gr), 32'b0011);
    drive(4'b1100, 4'b0000, pa, pd, 1, gr);
    check("all4_second", 32'(gr), 32'b1100);

    // Hazard: write/read same addr, third client takes port 1.
    pa = '0; pd = '0; pa[0] = 4'd3; pa[1] = 4'd3; pa[2] = 4'd7; pd[0] = 16'h1234;
    drive(4'b0111, 4'b0001, pa, pd, 1, gr);
    check("hazard_gnt", 32'(gr), 32'b0101);
    drive(4'b0010, 4'b0000, pa, pd, 1, gr);
    check("hazard_retry", 32'(gr), 32'b0010);
    check("hazard_cnt", 32'(conflict_cnt), 1);

    // Shared read of addr 9 by clients 1 and 3.
    pa = '0; pa[1] = 4'd9; pa[3] = 4'd9;
    drive(4'b1010, 4'b0000, pa, pd, 1, gr);
    check("shared_rd_gnt", 32'(gr), 32'b1010);
    drive(4'b0000, 4'b0000, pa, pd, 1, gr);
    check("shared_rd_cnt", 32'(conflict_cnt), 1);

    // Saturation: every cycle one write wins, the rest hazard.
    pa = '0; pd = '0;
    for (int i = 0; i < 4; i++) begin pa[i] = 4'd3; pd[i] = W'(i); end
    for (int n = 0; n < 65540; n++) drive(4'b1111, 4'b1111, pa, pd, 0, gr);
    drive(4'b1111, 4'b1111, pa, pd, 1, gr);
    check("sat_cnt", 32'(conflict_cnt), 32'hFFFF);

    repeat (3) drive(4'b0000, 4'b0000, pa, pd, 1, gr);
    for (int i = 0; i < 4; i++) check("drain_empty", exp_q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Upstream stage of memory_wrapper: arbitrates four client request streams onto the two memory ports (port 0 / port 1).
- Round-robin fairness, up to two grants per cycle, same-address hazard blocking, read-response routing back to the issuing client.
- Counts hazard-blocked cycles for debug.

Parameters:
DATA_WIDTH, 16, word width of memory and clients
DATA_DEPTH, 4, address width in bits (memory holds 2^DATA_DEPTH words)

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  4  client i request valid (bit i)
req_ready  output  4  client i request accepted this cycle (combinational)
req_we  input  4  client i: 1=write, 0=read
req_addr  input  4*DATA_DEPTH  client i address, slice [i*DATA_DEPTH +: DATA_DEPTH]
req_wdata  input  4*DATA_WIDTH  client i write data, slice [i*DATA_WIDTH +: DATA_WIDTH]
rsp_valid  output  4  client i read data valid (1-cycle pulse)
rsp_rdata  output  4*DATA_WIDTH  client i read data, valid only with rsp_valid[i]
mem_we0  output  1  port 0 write enable
mem_addr0  output  DATA_DEPTH  port 0 address
mem_wdata0  output  DATA_WIDTH  port 0 write data
mem_rdata0  input  DATA_WIDTH  port 0 read data (valid cycle after address)
mem_we1, mem_addr1, mem_wdata1, mem_rdata1  as port 0, for port 1
conflict_cnt  output  16  saturating count of hazard-blocked cycles

Behaviour:
- Reset (async assert, sync deassert to clk): rr_ptr=0, in-flight tags cleared, rsp_valid=0, conflict_cnt=0. Mid-operation reset drops all in-flight reads; no rsp_valid after release for pre-reset grants.
- Handshake: transfer when req_valid[i] & req_ready[i]. Client holds we/addr/wdata stable while valid & !ready. req_ready depends on current req_valid/we/addr only (no loop through ready).
- Scan order per cycle: clients rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
- Grant A: first valid client in scan order -> port 0.
- Grant B: next valid client after A whose addr != A.addr, or whose addr == A.addr with both reads -> port 1. Candidates with same addr as A where either is a write are skipped (hazard) and scan continues.
- Client granted at most once per cycle; at most 2 grants per cycle.
- Unused port: mem_weX=0, mem_addrX=0, mem_wdataX=0. Port outputs combinational from grant.
- rr_ptr update at clk edge: (index of last granted client + 1) mod 4; unchanged when no grants.
- Read latency: read granted in cycle N -> rsp_valid[i]=1 in cycle N+1 with rsp_rdata slice = mem_rdataX of the port used. Implemented by registering {valid, client id} per port. Writes produce no response. Other rsp_rdata slices drive 0.
- Write then read of same addr in consecutive cycles: read returns new data (memory write-first across cycles); same-cycle hazard is prevented by rule above.
- conflict_cnt: +1 at each edge where at least one valid candidate was skipped for hazard; saturates at 16'hFFFF.
- Throughput: with all four valid and non-conflicting, 2 grants/cycle, each client served once per 2 cycles.

Test Plan:
- Reset: rst_n low mid-stream -> rsp_valid=0, conflict_cnt=0, mem_we0/1=0 immediately (async); after release first grant goes to client 0.
- Single client: client 2 writes 0xBEEF to addr 5, then reads addr 5 -> mem_we0=1/addr0=5 cycle N; read grant cycle N+1; rsp_valid[2]=1, rdata=0xBEEF in N+2.
- All four reading distinct addrs 1..4, rr_ptr=0 -> cycle N grants clients 0 (port0), 1 (port1); N+1 grants 2, 3; responses each one cycle later, correct per-client data.
- Hazard: client 0 write addr 3, client 1 read addr 3, client 2 read addr 7 -> grants 0 and 2, client 1 ready=0, conflict_cnt=1; client 1 granted next cycle, reads written value.
- Two reads same addr 9 (clients 1, 3) -> both granted same cycle, both rsp_valid next cycle with identical data, conflict_cnt unchanged.
- Saturation: force 70000 hazard cycles -> conflict_cnt holds 16'hFFFF.
